mips_mem_responder: RTL and testbench
=====================================

// Module: mips_mem_responder
// PURPOSE
//  Memory-side responder for the pipelined MIPS core: serves instruction fetches (IF) and LW/SW data
//  accesses (MEM) from one single-ported word array. Arbitrates two request ports, returns read data
//  after a fixed pipelined latency. Replaces the core's direct Mem[] indexing with a handshaked port.
// PARAMETERS
//  AW       10   word-address width; array depth = 2**AW words
//  DW       32   data word width
//  RD_LAT   2    read latency in cycles, grant to rsp_valid (1..4)
//  STARVE   3    max consecutive data grants while a fetch waits; the next grant goes to fetch
// PORTS
//  clk           in   1      single clock, all logic on posedge
//  rst_n         in   1      synchronous reset, active low
//  i_req_valid   in   1      fetch request valid
//  i_req_addr    in   AW     fetch word address (PC)
//  i_req_ready   out  1      fetch request accepted this cycle
//  i_rsp_valid   out  1      fetch data valid, one-cycle pulse
//  i_rsp_data    out  DW     fetched instruction word
//  d_req_valid   in   1      data request valid
//  d_req_we      in   1      1 = store (SW), 0 = load (LW)
//  d_req_addr    in   AW     data word address (ALUOut)
//  d_req_wdata   in   DW     store data (B operand)
//  d_req_be      in   4      byte enables, bit n = byte n (used only with MEM_BYTE_EN)
//  d_req_ready   out  1      data request accepted this cycle
//  d_rsp_valid   out  1      load data valid, or store acknowledge, one-cycle pulse
//  d_rsp_rdata   out  DW     load data (0 for store acks)
// BEHAVIOUR
//  - Reset: all *_ready, *_rsp_valid = 0; rsp data = 0; starvation counter = 0; latency pipe flushed.
//    Array contents are not reset (preloaded by bench via hierarchical write).
//  - Handshake: request transfers when valid && ready on the same edge. Requester holds addr/data
//    stable until accepted. Responses carry no backpressure; consumer must take them on the pulse.
//  - Arbitration, one grant per cycle: only one valid -> grant it. Both valid -> data wins unless
//    starve count == STARVE, then fetch wins. Counter increments on each data grant while i_req_valid
//    is high and fetch is not granted; clears on any fetch grant or when i_req_valid is low.
//  - ready is combinational from valids and counter: granted port ready=1, other ready=0.
//  - Read: array read at grant; data travels RD_LAT-stage pipe tagged {port, is_store}; rsp_valid on
//    exactly cycle grant+RD_LAT. Fully pipelined: back-to-back grants give back-to-back responses.
//  - Write: array updated at grant edge; d_rsp_valid ack with rdata=0 at grant+RD_LAT (order kept).
//  - Read-after-write same address in consecutive cycles: later read returns the new data.
//  - Address wraps modulo 2**AW (upper bits of a wider source are dropped by the caller).
//  - Reset asserted mid-flight: pipe flushed, no response from in-flight grants is ever emitted;
//    a write granted on the same edge that rst_n is sampled low is discarded.
//  - Responses per port are strictly in grant order; the two ports never pulse from one grant.
// CONFIGURATION
//  MEM_BYTE_EN defined: stores write only bytes with d_req_be[n]=1; be=4'b0000 is a no-op store
//    that still acks. Requires DW==32.
//  MEM_BYTE_EN undefined: d_req_be ignored; every store writes the full word.
// TESTING
//  1 Reset: rst_n=0 2 cycles with both valids high -> all ready/rsp_valid 0; first rsp only after release.
//  2 Fetch stream: preload [0..3]=A0..A3, i_req addr 0,1,2,3 back-to-back -> i_rsp_data A0..A3 on
//    4 consecutive cycles, first at accept+RD_LAT.
//  3 Store-load: SW addr 5 data 32'hDEADBEEF, next cycle LW addr 5 -> ack(rdata 0), then rdata DEADBEEF.
//  4 Contention: both valid continuously, STARVE=3 -> grant pattern D,D,D,I,D,D,D,I; no fetch starved.
//  5 Byte enables (MEM_BYTE_EN): word 8 = 32'h11223344, SW be=4'b0101 data 32'hAABBCCDD -> LW
//    returns 32'h11BB33DD; without macro -> 32'hAABBCCDD.
//  6 Reset mid-flight: grant LW then drop rst_n 1 cycle before rsp -> no d_rsp_valid pulse; wrap: addr
//    2**AW-1 then 0 return those two distinct words.

Source files
------------

// File: rtl/mips_mem_responder.sv
// Single-ported word memory serving MIPS instruction fetches and LW/SW accesses with fixed read latency.
// Optional `define MEM_BYTE_EN enables per-byte store masking via d_req_be (requires DW == 32).
module mips_mem_responder #(
  parameter int AW     = 10,
  parameter int DW     = 32,
  parameter int RD_LAT = 2,
  parameter int STARVE = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req_valid,
  input  logic [AW-1:0] i_req_addr,
  output logic          i_req_ready,
  output logic          i_rsp_valid,
  output logic [DW-1:0] i_rsp_data,
  input  logic          d_req_valid,
  input  logic          d_req_we,
  input  logic [AW-1:0] d_req_addr,
  input  logic [DW-1:0] d_req_wdata,
  input  logic [3:0]    d_req_be,
  output logic          d_req_ready,
  output logic          d_rsp_valid,
  output logic [DW-1:0] d_rsp_rdata
);

  localparam int CW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE);
  localparam int LAST = RD_LAT - 1;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  logic [DW-1:0]     mem_q [0:(2**AW)-1];
  logic [CW-1:0]     starve_q, starve_d;
  logic              grant_i, grant_d;

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] store_q;
  port_e             port_q [RD_LAT];
  logic [DW-1:0]     data_q [RD_LAT];

  logic              vld_d, store_d;
  port_e             port_d;
  logic [DW-1:0]     data_d;

  // Data normally wins; a fetch that has watched STARVE data grants in a row takes the next slot.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (rst_n) begin
      if (d_req_valid && !(i_req_valid && (starve_q == STARVE_LIM))) begin
        grant_d = 1'b1;
      end else if (i_req_valid) begin
        grant_i = 1'b1;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!i_req_valid || grant_i) begin
      starve_d = '0;
    end else if (grant_d && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + CW'(1);
    end
  end

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  always_comb begin
    vld_d   = grant_i | grant_d;
    port_d  = grant_d ? PORT_D : PORT_I;
    store_d = grant_d & d_req_we;
    data_d  = '0;
    if (grant_i) begin
      data_d = mem_q[i_req_addr];
    end else if (grant_d && !d_req_we) begin
      data_d = mem_q[d_req_addr];
    end
  end

  // Reset clears the latency pipe, so grants still in flight never produce a response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
      vld_q    <= '0;
      store_q  <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        port_q[s] <= PORT_I;
        data_q[s] <= '0;
      end
    end else begin
      starve_q   <= starve_d;
      vld_q[0]   <= vld_d;
      store_q[0] <= store_d;
      port_q[0]  <= port_d;
      data_q[0]  <= data_d;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_q[s]   <= vld_q[s-1];
        store_q[s] <= store_q[s-1];
        port_q[s]  <= port_q[s-1];
        data_q[s]  <= data_q[s-1];
      end
    end
  end

  // The array itself is never reset; grant_d is already suppressed while rst_n is low.
  always_ff @(posedge clk) begin
    if (grant_d && d_req_we) begin
`ifdef MEM_BYTE_EN
      for (int b = 0; b < 4; b++) begin
        if (d_req_be[b]) begin
          mem_q[d_req_addr][8*b +: 8] <= d_req_wdata[8*b +: 8];
        end
      end
`else
      mem_q[d_req_addr] <= d_req_wdata;
`endif
    end
  end

`ifndef MEM_BYTE_EN
  logic unused_be;
  assign unused_be = ^d_req_be;
`endif

  assign i_rsp_valid = vld_q[LAST] && (port_q[LAST] == PORT_I);
  assign d_rsp_valid = vld_q[LAST] && (port_q[LAST] == PORT_D);
  assign i_rsp_data  = i_rsp_valid ? data_q[LAST] : '0;
  assign d_rsp_rdata = (d_rsp_valid && !store_q[LAST]) ? data_q[LAST] : '0;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: a reference memory model feeds per-port scoreboards of expected
// response data and due cycle; scenario tasks add targeted checks on top.
module tb_mips_mem_responder;

  localparam int AW     = 10;
  localparam int DW     = 32;
  localparam int RD_LAT = 2;
  localparam int STARVE = 3;

  localparam logic [31:0] WRAP_HI = 32'hC0DE_03FF;
  localparam logic [31:0] WRAP_LO = 32'hA0A0_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req_valid;
  logic [AW-1:0] i_req_addr;
  logic          i_req_ready;
  logic          i_rsp_valid;
  logic [DW-1:0] i_rsp_data;
  logic          d_req_valid;
  logic          d_req_we;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata;
  logic [3:0]    d_req_be;
  logic          d_req_ready;
  logic          d_rsp_valid;
  logic [DW-1:0] d_rsp_rdata;

  mips_mem_responder #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_be(d_req_be), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic [31:0] model [0:(2**AW)-1];
  exp_t        iQ[$];
  exp_t        dQ[$];

  // Scoreboard: push on every accepted request, pop on every response pulse.
  always @(negedge clk) begin
    exp_t e;
    if (i_rsp_valid) begin
      total++;
      if (iQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL i_rsp_unexpected cyc=%0d data=%h want no pulse", cyc, i_rsp_data);
      end else begin
        e = iQ.pop_front();
        if (i_rsp_data !== e.data || cyc != e.due) begin
          bad++;
          $display("[TB] FAIL i_rsp got data=%h cyc=%0d want data=%h cyc=%0d", i_rsp_data, cyc, e.data, e.due);
        end
      end
    end else if (iQ.size() > 0 && iQ[0].due < cyc) begin
      e = iQ.pop_front();
      total++;
      bad++;
      $display("[TB] FAIL i_rsp_missing got no pulse want data=%h at cyc=%0d", e.data, e.due);
    end
    if (d_rsp_valid) begin
      total++;
      if (dQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL d_rsp_unexpected cyc=%0d data=%h want no pulse", cyc, d_rsp_rdata);
      end else begin
        e = dQ.pop_front();
        if (d_rsp_rdata !== e.data || cyc != e.due) begin
          bad++;
          $display("[TB] FAIL d_rsp got data=%h cyc=%0d want data=%h cyc=%0d", d_rsp_rdata, cyc, e.data, e.due);
        end
      end
    end else if (dQ.size() > 0 && dQ[0].due < cyc) begin
      e = dQ.pop_front();
      total++;
      bad++;
      $display("[TB] FAIL d_rsp_missing got no pulse want data=%h at cyc=%0d", e.data, e.due);
    end
    if (rst_n === 1'b1) begin
      if (i_req_valid && i_req_ready) begin
        iQ.push_back('{data: model[i_req_addr], due: cyc + RD_LAT});
      end
      if (d_req_valid && d_req_ready) begin
        if (d_req_we) begin
`ifdef MEM_BYTE_EN
          for (int b = 0; b < 4; b++) begin
            if (d_req_be[b]) model[d_req_addr][8*b +: 8] = d_req_wdata[8*b +: 8];
          end
`else
          model[d_req_addr] = d_req_wdata;
`endif
          dQ.push_back('{data: 32'h0, due: cyc + RD_LAT});
        end else begin
          dQ.push_back('{data: model[d_req_addr], due: cyc + RD_LAT});
        end
      end
    end
  end

  // Request drivers: entered just after a posedge, return just after the granting posedge.
  task automatic issueI(input logic [AW-1:0] a);
    bit ok = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr  = a;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (i_req_ready) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      total++;
      bad++;
      $display("[TB] FAIL i_req_timeout addr=%0d got no ready want ready within 50 cycles", a);
    end
    i_req_valid = 1'b0;
  endtask

  task automatic issueD(input logic we, input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] be);
    bit ok = 1'b0;
    d_req_valid = 1'b1;
    d_req_we    = we;
    d_req_addr  = a;
    d_req_wdata = wd;
    d_req_be    = be;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (d_req_ready) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      total++;
      bad++;
      $display("[TB] FAIL d_req_timeout addr=%0d got no ready want ready within 50 cycles", a);
    end
    d_req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && (iQ.size() != 0 || dQ.size() != 0); n++) @(negedge clk);
    @(posedge clk);
    #1;
    total++;
    if (iQ.size() != 0 || dQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain got pending i=%0d d=%0d want 0 0", iQ.size(), dQ.size());
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr  = '0;
    d_req_valid = 1'b1;
    d_req_we    = 1'b0;
    d_req_addr  = '0;
    d_req_wdata = '0;
    d_req_be    = 4'hF;
    repeat (2) begin
      @(negedge clk);
      total++;
      if ({i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid} !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL reset_flags got ir=%b dr=%b iv=%b dv=%b want all 0", i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid);
      end
      total++;
      if (i_rsp_data !== 32'h0 || d_rsp_rdata !== 32'h0) begin
        bad++;
        $display("[TB] FAIL reset_data got i=%h d=%h want 0 0", i_rsp_data, d_rsp_rdata);
      end
    end
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    rst_n       = 1'b1;
  endtask

  task automatic test_fetch_stream();
    int t0 = cyc;
    for (int k = 0; k < 4; k++) issueI(AW'(k));
    total++;
    if (cyc - t0 != 4) begin
      bad++;
      $display("[TB] FAIL fetch_stream_accepts got %0d cycles want 4", cyc - t0);
    end
    drain();
  endtask

  task automatic test_store_load();
    logic [31:0] got [2];
    int cnt = 0;
    issueD(1'b1, AW'(5), 32'hDEADBEEF, 4'hF);
    issueD(1'b0, AW'(5), 32'h0, 4'h0);
    for (int n = 0; n < 10 && cnt < 2; n++) begin
      @(negedge clk);
      if (d_rsp_valid) begin
        got[cnt] = d_rsp_rdata;
        cnt++;
      end
    end
    total++;
    if (cnt != 2 || got[0] !== 32'h0 || got[1] !== 32'hDEADBEEF) begin
      bad++;
      $display("[TB] FAIL store_load got n=%0d %h %h want n=2 00000000 deadbeef", cnt, got[0], got[1]);
    end
    drain();
  endtask

  task automatic test_contention();
    logic wantD [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    i_req_valid = 1'b1;
    i_req_addr  = AW'(12);
    d_req_valid = 1'b1;
    d_req_we    = 1'b0;
    d_req_addr  = AW'(13);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (d_req_ready !== wantD[k] || i_req_ready !== !wantD[k]) begin
        bad++;
        $display("[TB] FAIL contention_grant%0d got i=%b d=%b want i=%b d=%b", k, i_req_ready, d_req_ready, !wantD[k], wantD[k]);
      end
      @(posedge clk);
      #1;
    end
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    drain();
  endtask

  task automatic test_byte_en();
    logic [31:0] want;
    logic [31:0] got = 32'h0;
    int cnt = 0;
`ifdef MEM_BYTE_EN
    want = 32'h11BB33DD;
`else
    want = 32'hAABBCCDD;
`endif
    issueD(1'b1, AW'(8), 32'hAABBCCDD, 4'b0101);
    issueD(1'b0, AW'(8), 32'h0, 4'h0);
    for (int n = 0; n < 10 && cnt < 2; n++) begin
      @(negedge clk);
      if (d_rsp_valid) begin
        got = d_rsp_rdata;
        cnt++;
      end
    end
    total++;
    if (cnt != 2 || got !== want) begin
      bad++;
      $display("[TB] FAIL byte_en got n=%0d data=%h want n=2 data=%h", cnt, got, want);
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    logic [31:0] got [2];
    int cnt = 0;
    issueD(1'b0, AW'(20), 32'h0, 4'h0);
    rst_n = 1'b0;
    iQ.delete();
    dQ.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      total++;
      if (d_rsp_valid !== 1'b0 || i_rsp_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL midflight_rsp got iv=%b dv=%b want 0 0", i_rsp_valid, d_rsp_valid);
      end
    end
    @(posedge clk);
    #1;
    issueD(1'b0, AW'((2**AW) - 1), 32'h0, 4'h0);
    issueD(1'b0, AW'(0), 32'h0, 4'h0);
    for (int n = 0; n < 10 && cnt < 2; n++) begin
      @(negedge clk);
      if (d_rsp_valid) begin
        got[cnt] = d_rsp_rdata;
        cnt++;
      end
    end
    total++;
    if (cnt != 2 || got[0] !== WRAP_HI || got[1] !== WRAP_LO) begin
      bad++;
      $display("[TB] FAIL wrap got n=%0d %h %h want n=2 %h %h", cnt, got[0], got[1], WRAP_HI, WRAP_LO);
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      logic [31:0] v;
      v = 32'h5A00_0000 ^ (i * 32'h0001_0003);
      if (i < 4) v = WRAP_LO | 32'(i);
      if (i == 8) v = 32'h11223344;
      if (i == (2**AW) - 1) v = WRAP_HI;
      model[i]     = v;
      dut.mem_q[i] = v;
    end
    test_reset();
    test_fetch_stream();
    test_store_load();
    test_contention();
    test_byte_en();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
